// File: rtl/regfile_mp_pkg.sv
// Shared definitions for the multi-port register file: state encodings, byte width, PC index helper.
// Imported by the top and the byte-merge datapath.
package regfile_mp_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_RUN   = 1'b1
    } rf_state_e;

    // The top address of the register space is the PC, which is never stored.
    function automatic int reg_pc_idx(input int addr_width);
        return (1 << addr_width) - 1;
    endfunction

endpackage

// File: rtl/regfile_byte_merge.sv
// Combinational byte merge of two write ports over an old word; latency 0, no backpressure.
// Port 0 wins on the bytes it enables, port 1 (full word) fills the rest, else the old byte stays.
module regfile_byte_merge
    import regfile_mp_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0]        old_dat,
    input  logic                         we0,
    input  logic [DATA_WIDTH/BYTE_W-1:0] wbe0,
    input  logic [DATA_WIDTH-1:0]        wd0,
    input  logic                         we1,
    input  logic [DATA_WIDTH-1:0]        wd1,
    output logic [DATA_WIDTH-1:0]        merged
);

    always_comb begin
        merged = old_dat;
        for (int k = 0; k < DATA_WIDTH/BYTE_W; k++) begin
            if (we0 && wbe0[k]) begin
                merged[k*BYTE_W +: BYTE_W] = wd0[k*BYTE_W +: BYTE_W];
            end else if (we1) begin
                merged[k*BYTE_W +: BYTE_W] = wd1[k*BYTE_W +: BYTE_W];
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Two-write, NUM_RD-read register file with byte-enabled port 0, optional write->read bypass and a reset sweep.
// Reads are registered (1 cycle); writes to the PC index are reported on pc_wr/pc_wd one cycle later.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_RD     = 3,
    parameter int BYPASS     = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_RD*ADDR_WIDTH-1:0]   rd_a,
    output logic [NUM_RD*DATA_WIDTH-1:0]   rd_data,
    input  logic                           we0,
    input  logic [ADDR_WIDTH-1:0]          wa0,
    input  logic [DATA_WIDTH/BYTE_W-1:0]   wbe0,
    input  logic [DATA_WIDTH-1:0]          wd0,
    input  logic                           we1,
    input  logic [ADDR_WIDTH-1:0]          wa1,
    input  logic [DATA_WIDTH-1:0]          wd1,
    input  logic [DATA_WIDTH-1:0]          pc_val,
    output logic                           pc_wr,
    output logic [DATA_WIDTH-1:0]          pc_wd,
    output logic                           ready
);

    localparam int NUM_ENT = (1 << ADDR_WIDTH) - 1;
    localparam logic [ADDR_WIDTH-1:0] PC_A   = ADDR_WIDTH'(reg_pc_idx(ADDR_WIDTH));
    localparam logic [ADDR_WIDTH-1:0] LAST_A = ADDR_WIDTH'(NUM_ENT - 1);

    rf_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] mem_q  [0:NUM_ENT-1];
    logic [DATA_WIDTH-1:0] mem_d  [0:NUM_ENT-1];
    logic [DATA_WIDTH-1:0] mem_wr [0:NUM_ENT-1];
    logic [DATA_WIDTH-1:0] rd_q   [0:NUM_RD-1];
    logic [DATA_WIDTH-1:0] rd_d   [0:NUM_RD-1];
    logic [DATA_WIDTH-1:0] rd_byp [0:NUM_RD-1];
    logic                  pc_wr_q, pc_wr_d;
    logic [DATA_WIDTH-1:0] pc_wd_q, pc_wd_d, pc_merged;
    logic                  we0_pc, we1_pc;

    // An all-zero byte enable makes port 0 a no-op, including for the PC pulse.
    assign we0_pc = we0 && (wa0 == PC_A) && (|wbe0);
    assign we1_pc = we1 && (wa1 == PC_A);

    for (genvar e = 0; e < NUM_ENT; e++) begin : g_ent
        regfile_byte_merge #(.DATA_WIDTH(DATA_WIDTH)) u_wr_merge (
            .old_dat (mem_q[e]),
            .we0     (we0 && (wa0 == ADDR_WIDTH'(e))),
            .wbe0    (wbe0),
            .wd0     (wd0),
            .we1     (we1 && (wa1 == ADDR_WIDTH'(e))),
            .wd1     (wd1),
            .merged  (mem_wr[e])
        );
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_WIDTH-1:0] ra;
        logic [DATA_WIDTH-1:0] rd_old;

        assign ra = rd_a[i*ADDR_WIDTH +: ADDR_WIDTH];

        always_comb begin
            rd_old = pc_val;
            for (int e = 0; e < NUM_ENT; e++) begin
                if (ra == ADDR_WIDTH'(e)) begin
                    rd_old = mem_q[e];
                end
            end
        end

        regfile_byte_merge #(.DATA_WIDTH(DATA_WIDTH)) u_byp_merge (
            .old_dat (rd_old),
            .we0     ((BYPASS != 0) && we0 && (wa0 == ra)),
            .wbe0    (wbe0),
            .wd0     (wd0),
            .we1     ((BYPASS != 0) && we1 && (wa1 == ra)),
            .wd1     (wd1),
            .merged  (rd_byp[i])
        );

        assign rd_data[i*DATA_WIDTH +: DATA_WIDTH] = rd_q[i];
    end

    regfile_byte_merge #(.DATA_WIDTH(DATA_WIDTH)) u_pc_merge (
        .old_dat (pc_val),
        .we0     (we0_pc),
        .wbe0    (wbe0),
        .wd0     (wd0),
        .we1     (we1_pc),
        .wd1     (wd1),
        .merged  (pc_merged)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mem_d   = mem_q;
        pc_wr_d = 1'b0;
        pc_wd_d = pc_wd_q;
        for (int i = 0; i < NUM_RD; i++) begin
            rd_d[i] = '0;
        end
        case (state_q)
            RF_CLEAR: begin
                for (int e = 0; e < NUM_ENT; e++) begin
                    if (cnt_q == ADDR_WIDTH'(e)) begin
                        mem_d[e] = '0;
                    end
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_A) begin
                    state_d = RF_RUN;
                end
            end
            RF_RUN: begin
                mem_d   = mem_wr;
                rd_d    = rd_byp;
                pc_wr_d = we0_pc || we1_pc;
                if (we0_pc || we1_pc) begin
                    pc_wd_d = pc_merged;
                end
            end
            default: state_d = RF_CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RF_CLEAR;
            cnt_q   <= '0;
            pc_wr_q <= 1'b0;
            pc_wd_q <= '0;
            for (int i = 0; i < NUM_RD; i++) begin
                rd_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mem_q   <= mem_d;
            pc_wr_q <= pc_wr_d;
            pc_wd_q <= pc_wd_d;
            rd_q    <= rd_d;
        end
    end

    assign pc_wr = pc_wr_q;
    assign pc_wd = pc_wd_q;
    assign ready = (state_q == RF_RUN);

endmodule

// File: tb/tb_regfile_mp.sv
// Directed checks of regfile_mp (default build, bypass on) plus a wider bypass-off build
// exercised with random traffic against a reference array.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [11:0] rd_a   = '0;
    logic [95:0] rd_data;
    logic        we0    = 1'b0;
    logic [3:0]  wa0    = '0;
    logic [3:0]  wbe0   = '0;
    logic [31:0] wd0    = '0;
    logic        we1    = 1'b0;
    logic [3:0]  wa1    = '0;
    logic [31:0] wd1    = '0;
    logic [31:0] pc_val = '0;
    logic        pc_wr;
    logic [31:0] pc_wd;
    logic        ready;

    logic [19:0]  rd_a2   = '0;
    logic [127:0] rd_data2;
    logic         we0_2   = 1'b0;
    logic [4:0]   wa0_2   = '0;
    logic [3:0]   wbe0_2  = '0;
    logic [31:0]  wd0_2   = '0;
    logic         we1_2   = 1'b0;
    logic [4:0]   wa1_2   = '0;
    logic [31:0]  wd1_2   = '0;
    logic [31:0]  pc_val2 = '0;
    logic         pc_wr2;
    logic [31:0]  pc_wd2;
    logic         ready2;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp1 [0:14];
    logic [31:0] m2   [0:30];

    always #5 clk = ~clk;

    regfile_mp u_dut (
        .clk(clk), .rst(rst), .rd_a(rd_a), .rd_data(rd_data),
        .we0(we0), .wa0(wa0), .wbe0(wbe0), .wd0(wd0),
        .we1(we1), .wa1(wa1), .wd1(wd1),
        .pc_val(pc_val), .pc_wr(pc_wr), .pc_wd(pc_wd), .ready(ready)
    );

    regfile_mp #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NUM_RD(4), .BYPASS(0)) u_dut2 (
        .clk(clk), .rst(rst), .rd_a(rd_a2), .rd_data(rd_data2),
        .we0(we0_2), .wa0(wa0_2), .wbe0(wbe0_2), .wd0(wd0_2),
        .we1(we1_2), .wa1(wa1_2), .wd1(wd1_2),
        .pc_val(pc_val2), .pc_wr(pc_wr2), .pc_wd(pc_wd2), .ready(ready2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] merge_word(input logic [31:0] old, input logic w0,
                                               input logic [3:0] be, input logic [31:0] d0,
                                               input logic w1, input logic [31:0] d1);
        logic [31:0] r;
        r = old;
        for (int k = 0; k < 4; k++) begin
            if (w0 && be[k]) r[k*8 +: 8] = d0[k*8 +: 8];
            else if (w1)     r[k*8 +: 8] = d1[k*8 +: 8];
        end
        return r;
    endfunction

    task automatic test_reset();
        int n;
        logic bad;
        rst = 1'b1;
        step();
        n_checks++;
        if (ready !== 1'b0 || rd_data !== 96'h0 || pc_wr !== 1'b0 || pc_wd !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_state: ready=%b rd_data=%h pc_wr=%b pc_wd=%h, want 0/0/0/0",
                     ready, rd_data, pc_wr, pc_wd);
        end
        rst = 1'b0;
        n = 0;
        bad = 1'b0;
        while (ready !== 1'b1 && n < 40) begin
            rd_a = {4'(n % 15), 4'((n + 5) % 15), 4'((n + 10) % 15)};
            step();
            n++;
            if (ready !== 1'b1 && rd_data !== 96'h0) bad = 1'b1;
        end
        n_checks++;
        if (n != 15) begin
            n_fail++;
            $display("FAIL sweep_len: ready after %0d cycles, want 15", n);
        end
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL sweep_rd_zero: nonzero rd_data during sweep, want 0");
        end
        for (int g = 0; g < 5; g++) begin
            rd_a = {4'(g*3 + 2), 4'(g*3 + 1), 4'(g*3)};
            step();
            n_checks++;
            if (rd_data !== 96'h0) begin
                n_fail++;
                $display("FAIL post_sweep_read r%0d..r%0d: got %h want 0", g*3, g*3 + 2, rd_data);
            end
        end
    endtask

    task automatic test_sweep_restart();
        int n;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int c = 0; c < 7; c++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n = 0;
        while (ready !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        n_checks++;
        if (n != 15) begin
            n_fail++;
            $display("FAIL sweep_restart: ready after %0d cycles, want 15", n);
        end
        n = 0;
        while (ready2 !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        n_checks++;
        if (ready2 !== 1'b1) begin
            n_fail++;
            $display("FAIL wide_sweep: ready2=%b, want 1", ready2);
        end
        for (int e = 0; e < 15; e++) exp1[e] = 32'h0;
        for (int e = 0; e < 31; e++) m2[e] = 32'h0;
    endtask

    task automatic test_byte_write();
        we1 = 1'b1; wa1 = 4'd3; wd1 = 32'h11223344;
        step();
        we1 = 1'b0;
        we0 = 1'b1; wa0 = 4'd3; wbe0 = 4'b0001; wd0 = 32'hAABBCCDD;
        step();
        we0 = 1'b0;
        rd_a = {4'd0, 4'd0, 4'd3};
        step();
        n_checks++;
        if (rd_data[31:0] !== 32'h112233DD) begin
            n_fail++;
            $display("FAIL byte_write: r3=%h want 112233dd", rd_data[31:0]);
        end
        we0 = 1'b1; wa0 = 4'd3; wbe0 = 4'b0000; wd0 = 32'hFFFFFFFF;
        step();
        we0 = 1'b0;
        step();
        n_checks++;
        if (rd_data[31:0] !== 32'h112233DD) begin
            n_fail++;
            $display("FAIL zero_be_noop: r3=%h want 112233dd", rd_data[31:0]);
        end
        exp1[3] = 32'h112233DD;
    endtask

    task automatic test_dual_bypass();
        we1 = 1'b1; wa1 = 4'd5; wd1 = 32'h12345678;
        we1_2 = 1'b1; wa1_2 = 5'd5; wd1_2 = 32'h12345678;
        step();
        we0 = 1'b1; wa0 = 4'd5; wbe0 = 4'b0011; wd0 = 32'h0000BEEF;
        we1 = 1'b1; wa1 = 4'd5; wd1 = 32'hCAFE0000;
        rd_a = {4'd0, 4'd0, 4'd5};
        we0_2 = 1'b1; wa0_2 = 5'd5; wbe0_2 = 4'b0011; wd0_2 = 32'h0000BEEF;
        we1_2 = 1'b1; wa1_2 = 5'd5; wd1_2 = 32'hCAFE0000;
        rd_a2 = {15'd0, 5'd5};
        step();
        we0 = 1'b0; we1 = 1'b0; we0_2 = 1'b0; we1_2 = 1'b0;
        n_checks++;
        if (rd_data[31:0] !== 32'hCAFEBEEF) begin
            n_fail++;
            $display("FAIL bypass_on: rd0=%h want cafebeef", rd_data[31:0]);
        end
        n_checks++;
        if (rd_data2[31:0] !== 32'h12345678) begin
            n_fail++;
            $display("FAIL bypass_off: rd0=%h want 12345678", rd_data2[31:0]);
        end
        step();
        n_checks++;
        if (rd_data[31:0] !== 32'hCAFEBEEF || rd_data2[31:0] !== 32'hCAFEBEEF) begin
            n_fail++;
            $display("FAIL dual_write_stored: r5=%h/%h want cafebeef", rd_data[31:0], rd_data2[31:0]);
        end
        exp1[5] = 32'hCAFEBEEF;
        m2[5]   = 32'hCAFEBEEF;
    endtask

    task automatic test_pc();
        logic bad;
        we1 = 1'b1; wa1 = 4'd15; wd1 = 32'h100;
        step();
        we1 = 1'b0;
        n_checks++;
        if (pc_wr !== 1'b1 || pc_wd !== 32'h100) begin
            n_fail++;
            $display("FAIL pc_write: pc_wr=%b pc_wd=%h want 1/00000100", pc_wr, pc_wd);
        end
        step();
        n_checks++;
        if (pc_wr !== 1'b0) begin
            n_fail++;
            $display("FAIL pc_pulse_len: pc_wr=%b want 0", pc_wr);
        end
        bad = 1'b0;
        for (int g = 0; g < 5; g++) begin
            rd_a = {4'(g*3 + 2), 4'(g*3 + 1), 4'(g*3)};
            step();
            if (rd_data !== {exp1[g*3 + 2], exp1[g*3 + 1], exp1[g*3]}) bad = 1'b1;
        end
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL pc_array_untouched: register contents changed");
        end
        pc_val = 32'h8;
        rd_a = {4'd15, 4'd3, 4'd15};
        step();
        n_checks++;
        if (rd_data !== {32'h8, 32'h112233DD, 32'h8}) begin
            n_fail++;
            $display("FAIL pc_read: rd_data=%h want 00000008_112233dd_00000008", rd_data);
        end
        pc_val = 32'h11111111;
        we0 = 1'b1; wa0 = 4'd15; wbe0 = 4'b0010; wd0 = 32'h0000AB00;
        step();
        we0 = 1'b0;
        n_checks++;
        if (pc_wr !== 1'b1 || pc_wd !== 32'h1111AB11) begin
            n_fail++;
            $display("FAIL pc_partial: pc_wr=%b pc_wd=%h want 1/1111ab11", pc_wr, pc_wd);
        end
    endtask

    task automatic test_random_wide();
        logic [4:0]  ra [0:3];
        logic [31:0] exp_rd [0:3];
        logic        exp_pw;
        logic [31:0] exp_pd;
        for (int c = 0; c < 600; c++) begin
            we0_2   = 1'($urandom_range(0, 1));
            wa0_2   = 5'($urandom_range(0, 31));
            wbe0_2  = 4'($urandom_range(0, 15));
            wd0_2   = $urandom;
            we1_2   = 1'($urandom_range(0, 1));
            wa1_2   = (c % 7 == 0) ? wa0_2 : 5'($urandom_range(0, 31));
            wd1_2   = $urandom;
            pc_val2 = $urandom;
            for (int p = 0; p < 4; p++) begin
                ra[p] = (p == 0 && c % 5 == 0) ? wa0_2 : 5'($urandom_range(0, 31));
                rd_a2[p*5 +: 5] = ra[p];
                exp_rd[p] = (ra[p] == 5'd31) ? pc_val2 : m2[ra[p]];
            end
            exp_pw = (we0_2 && wa0_2 == 5'd31 && wbe0_2 != 4'd0) || (we1_2 && wa1_2 == 5'd31);
            exp_pd = merge_word(pc_val2, we0_2 && wa0_2 == 5'd31, wbe0_2, wd0_2,
                                we1_2 && wa1_2 == 5'd31, wd1_2);
            for (int e = 0; e < 31; e++) begin
                m2[e] = merge_word(m2[e], we0_2 && wa0_2 == 5'(e), wbe0_2, wd0_2,
                                   we1_2 && wa1_2 == 5'(e), wd1_2);
            end
            step();
            for (int p = 0; p < 4; p++) begin
                n_checks++;
                if (rd_data2[p*32 +: 32] !== exp_rd[p]) begin
                    n_fail++;
                    $display("FAIL rand_rd c%0d port%0d a%0d: got %h want %h",
                             c, p, ra[p], rd_data2[p*32 +: 32], exp_rd[p]);
                end
            end
            n_checks++;
            if (pc_wr2 !== exp_pw || (exp_pw && pc_wd2 !== exp_pd)) begin
                n_fail++;
                $display("FAIL rand_pc c%0d: pc_wr=%b pc_wd=%h want %b/%h", c, pc_wr2, pc_wd2, exp_pw, exp_pd);
            end
        end
        we0_2 = 1'b0;
        we1_2 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sweep_restart();
        test_byte_write();
        test_dual_bypass();
        test_pc();
        test_random_wide();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
